// File: rtl/bk_add_pkg.sv
// Shared definitions for the multi-precision add/subtract controller:
// word width, FSM state encoding and the word-select helper.
package bk_add_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit offset of the low bit of word idx inside a packed multi-word vector.
  function automatic int word_lo(input int idx);
    return idx * WORD_W;
  endfunction

endpackage

// File: rtl/bk_mp_add_ctrl_adder.sv
// 16-bit Brent-Kung parallel-prefix adder, shared word by word by the controller.
// Carry-in is folded into the bit-0 generate so the prefix tree yields every carry directly.
module Brentkung_adder (
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic        Cin,
  output logic        Cout,
  output logic [15:0] SUM
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] pp;
  logic [15:0] c;

  always_comb begin
    p    = X ^ Y;
    g    = X & Y;
    g[0] = g[0] | (p[0] & Cin);
    pp   = p;
    // Up-sweep builds group terms at positions 2^(l+1)-1 modulo 2^(l+1).
    for (int l = 0; l < 4; l++) begin
      for (int i = (2 << l) - 1; i < 16; i += (2 << l)) begin
        g[i]  = g[i] | (pp[i] & g[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    end
    // Down-sweep fills the remaining prefixes from the completed ones.
    for (int l = 2; l >= 0; l--) begin
      for (int i = (3 << l) - 1; i < 16; i += (2 << l)) begin
        g[i] = g[i] | (pp[i] & g[i - (1 << l)]);
      end
    end
    c    = {g[14:0], Cin};
    SUM  = p ^ c;
    Cout = g[15];
  end

endmodule

// File: rtl/bk_mp_add_ctrl.sv
// Multi-precision add/subtract controller: one shared 16-bit Brent-Kung adder
// is stepped across up to MAX_WORDS words with the carry chained between words.
module bk_mp_add_ctrl
  import bk_add_pkg::*;
#(
  parameter int MAX_WORDS = 4,
  parameter int CNT_W     = $clog2(MAX_WORDS) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [WORD_W*MAX_WORDS-1:0]   req_a,
  input  logic [WORD_W*MAX_WORDS-1:0]   req_b,
  input  logic [CNT_W-1:0]              req_words,
  input  logic                          req_sub,
  input  logic                          req_cin,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [WORD_W*MAX_WORDS-1:0]   rsp_sum,
  output logic                          rsp_cout,
  output logic                          rsp_ovf
);

  localparam int W = WORD_W * MAX_WORDS;

  state_t             state_q;
  state_t             state_d;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic [CNT_W-1:0]   n_q;
  logic [CNT_W-1:0]   idx_q;
  logic [CNT_W-1:0]   words_eff;
  logic               carry_q;
  logic               alive_q;
  logic               accept;
  logic               last_word;
  logic [WORD_W-1:0]  x_word;
  logic [WORD_W-1:0]  y_word;
  logic [WORD_W-1:0]  add_sum;
  logic               add_cout;
  int                 sel_lo;
  int                 top_msb;

  assign req_ready = alive_q && (state_q == IDLE);
  assign accept    = req_ready && req_valid;
  assign last_word = (idx_q == n_q - CNT_W'(1));
  assign words_eff = (req_words == '0 || req_words > CNT_W'(MAX_WORDS)) ?
                     CNT_W'(MAX_WORDS) : req_words;

  // idx_q ends one past the last word after RUN, so the mux select is bounded.
  always_comb begin
    sel_lo  = (int'(idx_q) < MAX_WORDS) ? word_lo(int'(idx_q)) : 0;
    top_msb = (n_q == '0) ? WORD_W - 1 : word_lo(int'(n_q) - 1) + WORD_W - 1;
  end

  assign x_word = a_q[sel_lo +: WORD_W];
  assign y_word = b_q[sel_lo +: WORD_W];

  Brentkung_adder u_adder (
    .X    (x_word),
    .Y    (y_word),
    .Cin  (carry_q),
    .Cout (add_cout),
    .SUM  (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_word) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (accept) begin
        a_q     <= req_a;
        b_q     <= req_sub ? ~req_b : req_b;
        n_q     <= words_eff;
        carry_q <= req_sub | req_cin;
        idx_q   <= '0;
        sum_q   <= '0;
      end else if (state_q == RUN) begin
        sum_q[sel_lo +: WORD_W] <= add_sum;
        carry_q                 <= add_cout;
        idx_q                   <= idx_q + CNT_W'(1);
      end
    end
  end

  // Outputs are qualified by DONE so idle and reset views read as zero.
  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = rsp_valid ? sum_q : '0;
  assign rsp_cout  = rsp_valid && carry_q;
  assign rsp_ovf   = rsp_valid && (a_q[top_msb] == b_q[top_msb]) &&
                     (sum_q[top_msb] != a_q[top_msb]);

endmodule

// File: tb/tb_bk_mp_add_ctrl.sv
// Self-checking bench for bk_mp_add_ctrl: directed cases from the block's test
// plan plus randomized operations scored against a plain-arithmetic model.
module tb_bk_mp_add_ctrl;

  localparam int MAX_WORDS = 4;
  localparam int CNT_W     = 3;
  localparam int W         = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [W-1:0]     req_a;
  logic [W-1:0]     req_b;
  logic [CNT_W-1:0] req_words;
  logic             req_sub;
  logic             req_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_sum;
  logic             rsp_cout;
  logic             rsp_ovf;

  int tests = 0;
  int fails = 0;

  bk_mp_add_ctrl #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_words (req_words),
    .req_sub   (req_sub),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  // Two's-complement value of the low 16*n bits of v.
  function automatic logic signed [67:0] sext(input logic [63:0] v, input int n);
    logic signed [67:0] r;
    r = $signed({4'b0, v});
    if (v[16*n-1]) r = r - (68'sd1 <<< (16*n));
    return r;
  endfunction

  // Reference: modulo 2^(16n) arithmetic, no-borrow flag, signed range overflow.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input int words,
                       input bit sub, input bit cin, output int n,
                       output logic [63:0] s, output bit co, output bit ov);
    logic [63:0]        mask;
    logic [63:0]        am;
    logic [63:0]        bm;
    logic [67:0]        t;
    logic signed [67:0] sr;
    logic signed [67:0] hi;
    logic signed [67:0] lo;
    logic signed [67:0] ci;
    n    = (words == 0 || words > MAX_WORDS) ? MAX_WORDS : words;
    mask = (n == 4) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (16*n)) - 64'd1);
    am   = a & mask;
    bm   = b & mask;
    ci   = cin ? 68'sd1 : 68'sd0;
    if (sub) begin
      s  = (am - bm) & mask;
      co = (am >= bm);
      sr = sext(am, n) - sext(bm, n);
    end else begin
      t  = {4'b0, am} + {4'b0, bm} + {67'b0, cin};
      s  = t[63:0] & mask;
      co = t[16*n];
      sr = sext(am, n) + sext(bm, n) + ci;
    end
    hi = (68'sd1 <<< (16*n-1)) - 68'sd1;
    lo = -(68'sd1 <<< (16*n-1));
    ov = (sr > hi) || (sr < lo);
  endtask

  // Drives one request and waits for its response; rsp_ready is left as the caller set it.
  task automatic send_op(input logic [63:0] a, input logic [63:0] b, input int words,
                         input bit sub, input bit cin, output logic [63:0] s,
                         output bit co, output bit ov, output int lat, output bit to);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    req_a     = a;
    req_b     = b;
    req_words = CNT_W'(words);
    req_sub   = sub;
    req_cin   = cin;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    to  = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        lat = c;
        to  = 1'b0;
        break;
      end
    end
    s  = rsp_sum;
    co = rsp_cout;
    ov = rsp_ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    tests++;
    if ({req_ready, rsp_valid, rsp_cout, rsp_ovf} !== 4'b0 || rsp_sum !== 64'd0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: ready=%b valid=%b sum=%h cout=%b ovf=%b, all must be 0",
               req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_release: ready=%b valid=%b, required ready=1 valid=0",
               req_ready, rsp_valid);
    end
  endtask

  task automatic test_directed(input string name, input logic [63:0] a, input logic [63:0] b,
                               input int words, input bit sub, input bit cin,
                               input logic [63:0] exp_s, input bit exp_co, input bit exp_ov,
                               input int exp_lat);
    logic [63:0] s;
    bit co, ov, to;
    int lat;
    send_op(a, b, words, sub, cin, s, co, ov, lat, to);
    tests++;
    if (to || lat !== exp_lat) begin
      fails++;
      $display("[TB] FAIL %s_latency: got %0d (timeout=%0b), required %0d", name, lat, to, exp_lat);
    end
    tests++;
    if (s !== exp_s || co !== exp_co || ov !== exp_ov) begin
      fails++;
      $display("[TB] FAIL %s_result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
               name, s, co, ov, exp_s, exp_co, exp_ov);
    end
  endtask

  task automatic test_random(input int count);
    logic [63:0] a, b, s, es;
    bit co, ov, to, eco, eov, sub, cin;
    int lat, words, n;
    for (int k = 0; k < count; k++) begin
      a     = {$urandom, $urandom};
      b     = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_FFFF;
      if ($urandom_range(0, 5) == 0) b = 64'h8000_8000_8000_8000;
      words = $urandom_range(0, 7);
      sub   = $urandom_range(0, 1);
      cin   = $urandom_range(0, 1);
      model(a, b, words, sub, cin, n, es, eco, eov);
      send_op(a, b, words, sub, cin, s, co, ov, lat, to);
      tests++;
      if (to || lat != n || s !== es || co !== eco || ov !== eov) begin
        fails++;
        $display("[TB] FAIL random_%0d: a=%h b=%h w=%0d sub=%0b cin=%0b got sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
                 k, a, b, words, sub, cin, s, co, ov, lat, es, eco, eov, n);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] es, snap_s;
    bit eco, eov, snap_co, snap_ov, to;
    int n;
    model(64'h0000_0000_9ABC_DEF0, 64'h0000_0000_1234_5678, 2, 1'b0, 1'b1, n, es, eco, eov);
    rsp_ready = 1'b0;
    req_a     = 64'h0000_0000_9ABC_DEF0;
    req_b     = 64'h0000_0000_1234_5678;
    req_words = 3'd2;
    req_sub   = 1'b0;
    req_cin   = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        to = 1'b0;
        break;
      end
    end
    snap_s  = rsp_sum;
    snap_co = rsp_cout;
    snap_ov = rsp_ovf;
    tests++;
    if (to || snap_s !== es || snap_co !== eco || snap_ov !== eov) begin
      fails++;
      $display("[TB] FAIL bp_result: got sum=%h cout=%b ovf=%b timeout=%0b, required sum=%h cout=%b ovf=%b",
               snap_s, snap_co, snap_ov, to, es, eco, eov);
    end
    for (int c = 0; c < 5; c++) begin
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      req_words = 3'd1;
      req_valid = c[0] ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      tests++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_sum !== snap_s ||
          rsp_cout !== snap_co || rsp_ovf !== snap_ov) begin
        fails++;
        $display("[TB] FAIL bp_hold_%0d: valid=%b ready=%b sum=%h cout=%b ovf=%b, required valid=1 ready=0 sum=%h cout=%b ovf=%b",
                 c, rsp_valid, req_ready, rsp_sum, rsp_cout, rsp_ovf, snap_s, snap_co, snap_ov);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bp_release: ready=%b valid=%b, required ready=1 valid=0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    req_a     = 64'hFFFF_FFFF_FFFF_FFFF;
    req_b     = 64'h0000_0000_0000_0001;
    req_words = 3'd4;
    req_sub   = 1'b0;
    req_cin   = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({req_ready, rsp_valid, rsp_cout, rsp_ovf} !== 4'b0 || rsp_sum !== 64'd0) begin
      fails++;
      $display("[TB] FAIL midrst_outputs: ready=%b valid=%b sum=%h cout=%b ovf=%b, all must be 0",
               req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midrst_ready: got %b, required 1", req_ready);
    end
    for (int c = 0; c < 6; c++) begin
      tests++;
      if (rsp_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL midrst_stale_%0d: rsp_valid=%b, required 0", c, rsp_valid);
      end
      @(posedge clk); #1;
    end
    test_directed("midrst_next", 64'h0000_0000_0000_1234, 64'h0000_0000_0000_4321,
                  1, 1'b0, 1'b0, 64'h0000_0000_0000_5555, 1'b0, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    logic [63:0] es;
    bit eco, eov;
    int n, guard;
    int accepts[$];
    model(64'h0000_0000_8001_FFFF, 64'h0000_0000_7FFF_0001, 2, 1'b0, 1'b0, n, es, eco, eov);
    req_a     = 64'h0000_0000_8001_FFFF;
    req_b     = 64'h0000_0000_7FFF_0001;
    req_words = 3'd2;
    req_sub   = 1'b0;
    req_cin   = 1'b0;
    req_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (req_ready) accepts.push_back(c);
      if (rsp_valid) begin
        tests++;
        if (rsp_sum !== es || rsp_cout !== eco || rsp_ovf !== eov) begin
          fails++;
          $display("[TB] FAIL b2b_result_%0d: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   c, rsp_sum, rsp_cout, rsp_ovf, es, eco, eov);
        end
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    tests++;
    if (accepts.size() < 3) begin
      fails++;
      $display("[TB] FAIL b2b_count: got %0d accepts, required at least 3", accepts.size());
    end
    for (int k = 1; k < accepts.size(); k++) begin
      tests++;
      if (accepts[k] - accepts[k-1] != n + 2) begin
        fails++;
        $display("[TB] FAIL b2b_spacing_%0d: got %0d cycles, required %0d",
                 k, accepts[k] - accepts[k-1], n + 2);
      end
    end
    guard = 0;
    while (!(req_ready && !rsp_valid) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_words = '0;
    req_sub   = 1'b0;
    req_cin   = 1'b0;
    rsp_ready = 1'b1;
    #12;
    test_reset();
    test_directed("single_word", 64'h0001, 64'hFFFF, 1, 1'b0, 1'b0,
                  64'h0, 1'b1, 1'b0, 1);
    test_directed("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4, 1'b0, 1'b0,
                  64'h0, 1'b1, 1'b0, 4);
    test_directed("sub_borrow", 64'h0000_0005, 64'h0000_0007, 2, 1'b1, 1'b1,
                  64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0, 2);
    test_directed("ovf_1w", 64'h7FFF, 64'h0001, 1, 1'b0, 1'b0,
                  64'h8000, 1'b0, 1'b1, 1);
    test_directed("clamp_0w", 64'h7FFF, 64'h0001, 0, 1'b0, 1'b0,
                  64'h8000, 1'b0, 1'b0, 4);
    test_directed("clamp_7w", 64'h7FFF_0000_0000_0000, 64'h0001_0000_0000_0000, 7, 1'b0, 1'b0,
                  64'h8000_0000_0000_0000, 1'b0, 1'b1, 4);
    test_directed("upper_ignored", 64'hAAAA_BBBB_0000_FFFF, 64'hCCCC_DDDD_0000_0001, 1, 1'b0, 1'b1,
                  64'h0000_0000_0000_0001, 1'b1, 1'b0, 1);
    test_random(40);
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_random(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
